// File: rtl/seq_detector_if.sv
// rtl/seq_detector_if.sv - serial pattern detector control/status bundle
interface seq_detector_if #(
    parameter int W     = 6,
    parameter int CNT_W = 8
);
    logic             i;
    logic             en;
    logic             load;
    logic [W-1:0]     pat;
    logic             clear;
    logic             armed;
    logic             match;
    logic [CNT_W-1:0] count;
    logic [W-1:0]     window;

    modport master (
        output i, en, load, pat, clear,
        input  armed, match, count, window
    );

    modport slave (
        input  i, en, load, pat, clear,
        output armed, match, count, window
    );
endinterface

// File: rtl/seq_detector.sv
// rtl/seq_detector.sv - serial W-bit pattern detector with saturating match counter
module seq_detector #(
    parameter int W       = 6,
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    seq_detector_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HUNT = 2'd2
    } state_t;

    localparam int               FW        = $clog2(W + 1);
    localparam logic [FW-1:0]    FILL_FULL = FW'(W);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state_q,  state_d;
    logic [W-1:0]     pat_q,    pat_d;
    logic [W-1:0]     window_q, window_d;
    logic [FW-1:0]    fill_q,   fill_d;
    logic             match_q,  match_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             armed_q,  armed_d;

    logic [W-1:0]     shifted;
    logic [FW-1:0]    fill_inc;
    logic             hit;

    // Next-state: load re-arms from scratch; a sampled bit shifts the window and
    // is compared only once W bits have been collected since arm/restart.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        window_d = window_q;
        fill_d   = fill_q;
        count_d  = count_q;
        hit      = 1'b0;
        shifted  = {window_q[W-2:0], bus.i};
        fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;

        if (bus.load) begin
            pat_d    = bus.pat;
            window_d = '0;
            fill_d   = '0;
            state_d  = FILL;
        end else if (bus.en && (state_q != IDLE)) begin
            window_d = shifted;
            fill_d   = fill_inc;
            if (fill_inc == FILL_FULL) begin
                state_d = HUNT;
                if (shifted == pat_q) begin
                    hit = 1'b1;
                    if (OVERLAP == 0) begin
                        fill_d  = '0;
                        state_d = FILL;
                    end
                end
            end
        end

        match_d = hit;

        // clear takes priority over a coincident match increment
        if (bus.clear) begin
            count_d = '0;
        end else if (hit && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end

        armed_d = (state_d != IDLE);
    end

    // State and registered outputs, asynchronously cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            pat_q    <= '0;
            window_q <= '0;
            fill_q   <= '0;
            match_q  <= 1'b0;
            count_q  <= '0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            window_q <= window_d;
            fill_q   <= fill_d;
            match_q  <= match_d;
            count_q  <= count_d;
            armed_q  <= armed_d;
        end
    end

    assign bus.armed  = armed_q;
    assign bus.match  = match_q;
    assign bus.count  = count_q;
    assign bus.window = window_q;

endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 Parameter W, default 6: pattern and window width in bits.
REQ-002 Parameter OVERLAP, default 1: 1 allows overlapping matches, 0 restarts the hunt after each match.
REQ-003 Parameter CNT_W, default 8: match counter width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge; the serial source launches on the falling edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 i  in  1  serial data bit.
REQ-007 en  in  1  when 1, i is sampled this cycle.
REQ-008 load  in  1  one-cycle strobe: latch pat and arm the detector.
REQ-009 pat  in  W  pattern to detect, first-received bit at pat[W-1].
REQ-010 clear  in  1  one-cycle strobe: zero the match counter.
REQ-011 armed  out  1  1 in the HUNT or FILL state.
REQ-012 match  out  1  registered one-cycle pulse on detection.
REQ-013 count  out  CNT_W  saturating count of matches.
REQ-014 window  out  W  last W sampled bits, newest at window[0].

Function
REQ-015 The FSM SHALL have three states: IDLE (no pattern), FILL (fewer than W bits since arm or restart), HUNT (window full, compare active).
REQ-016 IDLE: en SHALL be ignored; load SHALL go to FILL.
REQ-017 On load, in any state, the block SHALL latch pat, clear window to 0 and the fill counter to 0, go to FILL, and discard the i bit of that cycle.
REQ-018 With en=1 and load=0 in FILL or HUNT, window SHALL update to {window[W-2:0], i} and the fill counter SHALL increment, saturating at W.
REQ-019 When the fill counter reaches W, the FSM SHALL move from FILL to HUNT.
REQ-020 match SHALL be 1 in the cycle after the edge on which the sampled bit makes {window[W-2:0], i} equal to the latched pattern, with the FSM in HUNT or entering HUNT on that bit. Latency is 1 cycle from the sampling edge.
REQ-021 match SHALL be 0 in every other cycle, including cycles with en=0.
REQ-022 If OVERLAP=1, the FSM SHALL stay in HUNT after a match.
REQ-023 If OVERLAP=0, a match SHALL reset the fill counter to 0 and return the FSM to FILL; window content SHALL be kept but not compared until W new bits arrive.
REQ-024 count SHALL increment by 1 per match and saturate at 2^CNT_W-1 with no wrap.
REQ-025 If clear and a match occur in the same cycle, clear SHALL win: count=0 and the match pulse is still emitted.
REQ-026 If load and clear occur in the same cycle, both SHALL take effect.
REQ-027 With en=0, window, fill counter and state SHALL hold.

Reset
REQ-028 When rst=0, the block SHALL asynchronously force: state=IDLE, pattern=0, window=0, fill counter=0, match=0, count=0, armed=0.
REQ-029 Reset asserted mid-stream SHALL abort any partial fill; no match SHALL be emitted until a new load and W fresh bits.
REQ-030 Release of rst SHALL take effect on the first rising edge at which rst=1.

Verification
REQ-031 Reset, then en=1 with stream 1,0,1,1,0,1 and no load -> armed=0, match never 1, count=0.
REQ-032 load pat=6'b101101, then stream 1,0,1,1,0,1 with en=1 every cycle -> one match pulse in the cycle after the 6th bit, count=1, window=6'b101101.
REQ-033 OVERLAP=1, pat=101101, stream 1,0,1,1,0,1,1,0,1 -> matches after bit 6 and bit 9, count=2. With OVERLAP=0, the same stream -> only the bit-6 match, count=1.
REQ-034 Same stream with en=0 inserted for 3 cycles between bits 3 and 4 -> same match positions relative to sampled bits, window held during the gap.
REQ-035 CNT_W=2, 5 consecutive matches -> count 1,2,3,3,3. A clear coinciding with a match -> match=1, count=0.
REQ-036 rst pulsed low after bit 4 of a matching stream, then bits 5-6 -> no match, state IDLE, all outputs 0.
